// File: rtl/i2c_apb_pkg.sv
// Register map, bit positions and reset values shared by the APB/I2C register block.
package i2c_apb_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h01;
  localparam logic [7:0] OFF_TXDATA   = 8'h02;
  localparam logic [7:0] OFF_RXDATA   = 8'h03;
  localparam logic [7:0] OFF_SADDR    = 8'h04;
  localparam logic [7:0] OFF_PRESCALE = 8'h05;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h06;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h07;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_STOP  = 2;
  localparam int CTRL_RW    = 3;
  localparam int CTRL_FLUSH = 7;

  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_EMPTY = 4;
  localparam int ST_TX_FULL  = 5;
  localparam int ST_BUSY     = 6;
  localparam int ST_NACK     = 7;

  localparam int IRQ_RX_AVAIL = 0;
  localparam int IRQ_NACK     = 1;
  localparam int IRQ_TX_OVF   = 2;
  localparam int IRQ_RX_OVF   = 3;

  localparam logic [7:0] CTRL_RST     = 8'h00;
  localparam logic [6:0] SADDR_RST    = 7'h00;
  localparam logic [7:0] IRQ_EN_RST   = 8'h00;
  localparam logic [3:1] IRQ_STAT_RST = 3'b000;

  // CTRL bits that act as one-cycle command strobes
  localparam logic [7:0] CTRL_SELFCLR = (8'h1 << CTRL_START) | (8'h1 << CTRL_STOP)
                                      | (8'h1 << CTRL_FLUSH);

endpackage

// File: rtl/apb_i2c_regif_if.sv
// APB3 slave bus bundle for the I2C register block.
interface apb_i2c_regif_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO; a push while full is dropped even if a pop occurs the same cycle.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_i2c_regif.sv
// APB register front-end for an I2C master core: control/status regs, TX/RX FIFOs, interrupts.
module apb_i2c_regif
  import i2c_apb_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         ADDR_W       = 8,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] PRESCALE_RST = 8'h04
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_i2c_regif_if.slave        apb,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  core_nack,
  input  logic                  core_busy,
  output logic [7:0]            ctrl_o,
  output logic [7:0]            slave_addr_o,
  output logic [7:0]            prescale_o,
  output logic                  irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic access, wr_acc, rd_acc;
  logic sel_ctrl, sel_status, sel_txdata, sel_rxdata;
  logic sel_saddr, sel_prescale, sel_irq_en, sel_irq_stat;
  logic mapped, err;
  logic [7:0] wdata8, rdata, status, irq_stat;

  logic [7:0] ctrl_q, prescale_q, irq_en_q;
  logic [6:0] saddr_q;
  logic [3:1] sticky_q, sticky_set, sticky_clr;
  logic       nack_q;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_pop, rx_full, rx_empty, flush;
  logic [7:0] rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic unused_counts;

  assign access     = apb.PSEL & apb.PENABLE;
  assign apb.PREADY = access;
  assign wr_acc     = access &  apb.PWRITE;
  assign rd_acc     = access & ~apb.PWRITE;
  assign wdata8     = apb.PWDATA[7:0];

  assign sel_ctrl     = (apb.PADDR == ADDR_W'(OFF_CTRL));
  assign sel_status   = (apb.PADDR == ADDR_W'(OFF_STATUS));
  assign sel_txdata   = (apb.PADDR == ADDR_W'(OFF_TXDATA));
  assign sel_rxdata   = (apb.PADDR == ADDR_W'(OFF_RXDATA));
  assign sel_saddr    = (apb.PADDR == ADDR_W'(OFF_SADDR));
  assign sel_prescale = (apb.PADDR == ADDR_W'(OFF_PRESCALE));
  assign sel_irq_en   = (apb.PADDR == ADDR_W'(OFF_IRQ_EN));
  assign sel_irq_stat = (apb.PADDR == ADDR_W'(OFF_IRQ_STAT));
  assign mapped = sel_ctrl | sel_status | sel_txdata | sel_rxdata
                | sel_saddr | sel_prescale | sel_irq_en | sel_irq_stat;

  // Wrong-direction accesses and FIFO over/underflow all report as slave errors
  assign err = access & ( ~mapped
                        | ( apb.PWRITE & (sel_status | sel_rxdata))
                        | (~apb.PWRITE &  sel_txdata)
                        | ( apb.PWRITE &  sel_txdata & tx_full)
                        | (~apb.PWRITE &  sel_rxdata & rx_empty));
  assign apb.PSLVERR = err;

  assign tx_push = wr_acc & sel_txdata & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_pop  = rd_acc & sel_rxdata & ~rx_empty;
  assign flush   = wr_acc & sel_ctrl & wdata8[CTRL_FLUSH];

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .PCLK(PCLK), .PRESETn(PRESETn), .flush(flush),
    .push(tx_push), .din(wdata8), .pop(tx_pop), .dout(tx_data),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .PCLK(PCLK), .PRESETn(PRESETn), .flush(flush),
    .push(rx_valid), .din(rx_data), .pop(rx_pop), .dout(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign unused_counts = ^{tx_count, rx_count};
  assign tx_valid      = ~tx_empty;

  assign status   = {core_nack, core_busy, tx_full, tx_empty, rx_full, rx_empty, 2'b00};
  assign irq_stat = {4'b0000, sticky_q, ~rx_empty};

  assign sticky_set[IRQ_NACK]   = core_nack & ~nack_q;
  assign sticky_set[IRQ_TX_OVF] = wr_acc & sel_txdata & tx_full;
  assign sticky_set[IRQ_RX_OVF] = rx_valid & rx_full;
  assign sticky_clr = (wr_acc && sel_irq_stat) ? wdata8[3:1] : 3'b000;

  always_comb begin
    rdata = '0;
    if (rd_acc && !err) begin
      if (sel_ctrl)          rdata = ctrl_q;
      else if (sel_status)   rdata = status;
      else if (sel_rxdata)   rdata = rx_head;
      else if (sel_saddr)    rdata = {1'b0, saddr_q};
      else if (sel_prescale) rdata = prescale_q;
      else if (sel_irq_en)   rdata = irq_en_q;
      else if (sel_irq_stat) rdata = irq_stat;
    end
  end
  assign apb.PRDATA = DATA_W'(rdata);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q     <= CTRL_RST;
      saddr_q    <= SADDR_RST;
      prescale_q <= PRESCALE_RST;
      irq_en_q   <= IRQ_EN_RST;
      sticky_q   <= IRQ_STAT_RST;
      nack_q     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_acc && sel_ctrl) ctrl_q <= wdata8;
      else                    ctrl_q <= ctrl_q & ~CTRL_SELFCLR;
      if (wr_acc && sel_saddr)    saddr_q    <= wdata8[6:0];
      if (wr_acc && sel_prescale) prescale_q <= wdata8;
      if (wr_acc && sel_irq_en)   irq_en_q   <= wdata8;
      // Hardware set is OR-ed after the clear so it wins a same-cycle collision
      sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
      nack_q   <= core_nack;
      irq      <= |(irq_stat & irq_en_q);
    end
  end

  assign ctrl_o       = ctrl_q;
  assign slave_addr_o = {saddr_q, ctrl_q[CTRL_RW]};
  assign prescale_o   = prescale_q;

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Directed bench for apb_i2c_regif with queue scoreboards for reads, TX drain and RX order.
module tb_apb_i2c_regif;
  import i2c_apb_pkg::*;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_i2c_regif_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  logic [7:0] tx_data, rx_data, ctrl_o, slave_addr_o, prescale_o;
  logic tx_valid, tx_ready, rx_valid, core_nack, core_busy, irq;

  apb_i2c_regif #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(4), .PRESCALE_RST(8'h04)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus.slave),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .core_nack(core_nack), .core_busy(core_busy),
    .ctrl_o(ctrl_o), .slave_addr_o(slave_addr_o), .prescale_o(prescale_o), .irq(irq)
  );

  typedef struct packed { logic [7:0] data; logic err; } rd_exp_t;
  rd_exp_t    rdq[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int passes = 0, fails = 0, total = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                      input logic rxv, input logic [7:0] rxb,
                      output logic [7:0] rd, output logic err, output logic rdy);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    if (rxv) begin rx_valid = 1'b1; rx_data = rxb; end
    #3;
    rd = bus.PRDATA; err = bus.PSLVERR; rdy = bus.PREADY;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp_d, input logic exp_e);
    logic [7:0] d; logic e, r; rd_exp_t x;
    rdq.push_back('{data: exp_d, err: exp_e});
    xfer(1'b0, addr, 8'h00, 1'b0, 8'h00, d, e, r);
    x = rdq.pop_front();
    check(tag, {6'd0, r, e, d}, {6'd0, 1'b1, x.err, x.data});
  endtask

  task automatic wr(input string tag, input logic [7:0] addr, input logic [7:0] wd, input logic exp_e);
    logic [7:0] d; logic e, r;
    xfer(1'b1, addr, wd, 1'b0, 8'h00, d, e, r);
    check(tag, {r, e}, {1'b1, exp_e});
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge PCLK); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d; logic e, r; rd_exp_t x;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; core_nack = 0; core_busy = 0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Reset values
    check("rst_ctrl_o", ctrl_o, 8'h00);
    check("rst_prescale_o", prescale_o, 8'h04);
    check("rst_irq", irq, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("idle_prdata", bus.PRDATA, 8'h00);
    rd("rst_CTRL", OFF_CTRL, 8'h00, 1'b0);
    rd("rst_STATUS", OFF_STATUS, 8'h14, 1'b0);
    rd("rst_SADDR", OFF_SADDR, 8'h00, 1'b0);
    rd("rst_PRESCALE", OFF_PRESCALE, 8'h04, 1'b0);
    rd("rst_IRQ_EN", OFF_IRQ_EN, 8'h00, 1'b0);
    rd("rst_IRQ_STAT", OFF_IRQ_STAT, 8'h00, 1'b0);

    // TX overflow and drain order
    for (int i = 1; i <= 4; i++) begin
      txq.push_back(8'(i * 8'h11));
      wr("tx_push", OFF_TXDATA, 8'(i * 8'h11), 1'b0);
    end
    wr("tx_ovf_err", OFF_TXDATA, 8'h55, 1'b1);
    rd("tx_full_STATUS", OFF_STATUS, 8'h24, 1'b0);
    rd("tx_ovf_IRQ_STAT", OFF_IRQ_STAT, 8'h04, 1'b0);
    @(posedge PCLK); #1 tx_ready = 1'b1;
    for (int i = 0; i < 10 && txq.size() > 0; i++) begin
      @(negedge PCLK);
      if (tx_valid) check("tx_data", tx_data, txq.pop_front());
    end
    @(posedge PCLK); #1 tx_ready = 1'b0;
    check("tx_drained", 16'(txq.size()), 16'd0);
    check("tx_valid_after_drain", tx_valid, 1'b0);
    wr("w1c_tx_ovf", OFF_IRQ_STAT, 8'h04, 1'b0);
    rd("tx_ovf_cleared", OFF_IRQ_STAT, 8'h00, 1'b0);

    // Single RX byte then underflow
    pulse_rx(8'hA5);
    rd("rx_avail", OFF_IRQ_STAT, 8'h01, 1'b0);
    rd("rx_pop", OFF_RXDATA, 8'hA5, 1'b0);
    rd("rx_underflow", OFF_RXDATA, 8'h00, 1'b1);

    // Push and pop on the RX FIFO in the same cycle
    for (int i = 1; i <= 3; i++) begin
      rxq.push_back(8'(i));
      pulse_rx(8'(i));
    end
    rdq.push_back('{data: rxq.pop_front(), err: 1'b0});
    rxq.push_back(8'h04);
    xfer(1'b0, OFF_RXDATA, 8'h00, 1'b1, 8'h04, d, e, r);
    x = rdq.pop_front();
    check("rx_simul_read", {e, d}, {x.err, x.data});
    check("rx_simul_count", dut.u_rx_fifo.count, 3);
    for (int i = 0; i < 3; i++) rd("rx_order", OFF_RXDATA, rxq.pop_front(), 1'b0);
    check("rx_count_empty", dut.u_rx_fifo.count, 0);

    // NACK interrupt
    wr("irq_en", OFF_IRQ_EN, 8'h02, 1'b0);
    @(posedge PCLK); #1 core_nack = 1'b1;
    @(posedge PCLK); #1 core_nack = 1'b0;
    check("irq_one_cycle", irq, 1'b0);
    @(posedge PCLK); #1;
    check("irq_two_cycles", irq, 1'b1);
    rd("nack_IRQ_STAT", OFF_IRQ_STAT, 8'h02, 1'b0);
    wr("w1c_nack", OFF_IRQ_STAT, 8'h02, 1'b0);
    @(posedge PCLK); #1;
    check("irq_cleared", irq, 1'b0);

    // Plain registers and derived outputs
    wr("w_saddr", OFF_SADDR, 8'hDA, 1'b0);
    rd("r_saddr", OFF_SADDR, 8'h5A, 1'b0);
    wr("w_ctrl", OFF_CTRL, 8'h09, 1'b0);
    check("slave_addr_o", slave_addr_o, 8'hB5);
    rd("r_ctrl", OFF_CTRL, 8'h09, 1'b0);
    wr("w_prescale", OFF_PRESCALE, 8'h33, 1'b0);
    check("prescale_o", prescale_o, 8'h33);

    // Error accesses, RX overflow, flush
    rd("unmapped_rd", 8'h09, 8'h00, 1'b1);
    wr("status_wr", OFF_STATUS, 8'hFF, 1'b1);
    wr("rxdata_wr", OFF_RXDATA, 8'hFF, 1'b1);
    rd("txdata_rd", OFF_TXDATA, 8'h00, 1'b1);
    rd("status_unchanged", OFF_STATUS, 8'h14, 1'b0);
    wr("tx_a", OFF_TXDATA, 8'h77, 1'b0);
    wr("tx_b", OFF_TXDATA, 8'h78, 1'b0);
    for (int i = 0; i < 5; i++) pulse_rx(8'(8'h61 + i));
    core_busy = 1'b1;
    rd("full_busy_STATUS", OFF_STATUS, 8'h48, 1'b0);
    rd("rx_ovf_IRQ_STAT", OFF_IRQ_STAT, 8'h09, 1'b0);
    wr("ctrl_flush", OFF_CTRL, 8'h86, 1'b0);
    check("ctrl_strobes_set", ctrl_o, 8'h86);
    check("flush_tx_valid", tx_valid, 1'b0);
    @(posedge PCLK); #1;
    check("ctrl_strobes_clear", ctrl_o, 8'h00);
    core_busy = 1'b0;
    rd("flushed_STATUS", OFF_STATUS, 8'h14, 1'b0);
    rd("sticky_after_flush", OFF_IRQ_STAT, 8'h08, 1'b0);

    // Reset in the middle of a TXDATA write
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = OFF_TXDATA; bus.PWDATA = 8'h99;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    check("async_rst_prescale", prescale_o, 8'h04);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    PRESETn = 1'b1;
    check("rst_abort_tx_valid", tx_valid, 1'b0);
    rd("rst_abort_STATUS", OFF_STATUS, 8'h14, 1'b0);
    rd("rst_abort_IRQ_STAT", OFF_IRQ_STAT, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/apb_i2c_regif.md
APB_I2C_REGIF -- requirements
Module: apb_i2c_regif

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 8, APB data and register width; at least 8.
- ADDR_W, 8, APB address width.
- FIFO_DEPTH, 4, TX and RX FIFO depth; power of 2, at least 2.
- PRESCALE_RST, 8'h04, reset value of PRESCALE.

REQ-002 The block SHALL have these ports (clock and reset first):
- PCLK  in  1  clock.
- PRESETn  in  1  reset; asynchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- tx_data  out  8  TX FIFO head to the I2C core.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  core consumes tx_data.
- rx_data  in  8  byte received by the core.
- rx_valid  in  1  rx_data push strobe.
- core_nack  in  1  last byte NACKed.
- core_busy  in  1  bus busy (START seen, no STOP yet).
- ctrl_o  out  8  CTRL register to the core.
- slave_addr_o  out  8  {SADDR[6:0], rw}.
- prescale_o  out  8  PRESCALE register.
- irq  out  1  level interrupt.

Function
REQ-003 Register map, offsets in bytes, unlisted offsets unmapped:
- 0x00 CTRL, RW.
- 0x01 STATUS, RO.
- 0x02 TXDATA, WO, push.
- 0x03 RXDATA, RO, pop.
- 0x04 SADDR, RW, 7 bits.
- 0x05 PRESCALE, RW.
- 0x06 IRQ_EN, RW.
- 0x07 IRQ_STAT, RW1C.
REQ-004 A transfer SHALL complete when PSEL & PENABLE are both high; PREADY = PSEL & PENABLE, zero wait states.
REQ-005 Register writes and FIFO push/pop SHALL commit on the PCLK edge where PSEL & PENABLE & PREADY is high; no other cycle has side effects.
REQ-006 PRDATA SHALL be combinational during the access phase, upper bits zero-extended to DATA_W, and 0 outside the access phase.
REQ-007 CTRL bits: [0] enable, [1] start, [2] stop, [3] rw, [7] flush.
REQ-008 CTRL start, stop and flush SHALL self-clear one cycle after being written.
REQ-009 CTRL flush SHALL empty both FIFOs in the same cycle it is written.
REQ-010 slave_addr_o SHALL equal {SADDR, CTRL[3]}.
REQ-011 STATUS SHALL read as {nack, busy, tx_full, tx_empty, rx_full, rx_empty, 2'b00}.
REQ-012 A TXDATA write SHALL push PWDATA[7:0] into the TX FIFO.
REQ-013 A TXDATA write when the TX FIFO is full SHALL drop the data, assert PSLVERR, and set IRQ_STAT[2] (tx_ovf).
REQ-014 An RXDATA read SHALL return the RX FIFO head and pop it.
REQ-015 An RXDATA read when the RX FIFO is empty SHALL return 0, assert PSLVERR, and leave the FIFO unchanged.
REQ-016 tx_valid & tx_ready SHALL pop the TX FIFO.
REQ-017 rx_valid SHALL push rx_data into the RX FIFO.
REQ-018 rx_valid when the RX FIFO is full SHALL drop the byte and set IRQ_STAT[3] (rx_ovf).
REQ-019 A simultaneous push and pop on one FIFO SHALL both occur, count unchanged.
REQ-020 A push when the FIFO is full SHALL be rejected even if a pop occurs in the same cycle.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be clog2(FIFO_DEPTH)+1 bits.
REQ-022 IRQ_STAT[0] (rx_avail) SHALL equal the live !rx_empty; writes to it have no effect.
REQ-023 IRQ_STAT[1] (nack) SHALL be set on a rising edge of core_nack, which is sampled and registered.
REQ-024 IRQ_STAT[1], [2] and [3] SHALL be sticky and cleared only by writing 1 to them.
REQ-025 When a hardware set and a W1C clear hit the same IRQ_STAT bit in the same cycle, the set SHALL win.
REQ-026 irq SHALL be the registered value of |(IRQ_STAT & IRQ_EN).
REQ-027 Any access to an unmapped offset, any write to STATUS or RXDATA, and any read of TXDATA SHALL assert PSLVERR (with PREADY), have no side effect, and return 0.

Reset
REQ-028 On PRESETn low, asynchronously:
- CTRL = 0; SADDR = 0; PRESCALE = PRESCALE_RST; IRQ_EN = 0; IRQ_STAT = 0.
- Both FIFOs empty; irq = 0; the core_nack history register = 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer; no partial push or pop survives.

Structure
REQ-030 Package i2c_apb_pkg SHALL hold the register offsets, CTRL/STATUS/IRQ bit indices, and reset constants.
REQ-031 One sub-module, i2c_sync_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, count), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-032 Reset, then read every mapped register -> PRESCALE = 0x04, STATUS = 0x14, all others 0, PSLVERR = 0.
REQ-033 Write TXDATA 0x11, 0x22, 0x33, 0x44, 0x55 with tx_ready = 0 -> the 5th write gets PSLVERR and IRQ_STAT[2] = 1; drain -> tx_data sequence is 0x11..0x44.
REQ-034 Pulse rx_valid with 0xA5, then read RXDATA twice -> 0xA5 with PSLVERR = 0, then 0x00 with PSLVERR = 1.
REQ-035 Fill the RX FIFO to 3, then assert rx_valid and perform an RXDATA read in the same cycle -> count stays 3 and bytes come out in order.
REQ-036 Set IRQ_EN = 0x02 and pulse core_nack -> irq = 1 two cycles later; W1C IRQ_STAT = 0x02 -> irq = 0.
REQ-037 Read offset 0x09, write STATUS, and write CTRL = 0x86 -> the first two error with no effect; then start/stop/flush clear after one cycle and both FIFOs are empty.
